conv_line_buffer: RTL
=====================

// Module: conv_line_buffer
//
// PURPOSE
// - Upstream feeder for the 3x3 convolution stage: turns a raster-order 8-bit pixel
//   stream into 3-row pixel columns, one packed 24-bit column per accepted pixel.
// - Stores two previous lines in on-chip RAM (read-before-write); o_valid drives the
//   convolution's i_valid/clock-enable and o_done drives its i_done.
//
// PARAMETERS
// - WIDTH   640  pixels per line; col counter range 0..WIDTH-1
// - HEIGHT  480  lines per frame; row counter range 0..HEIGHT-1
// - ADDR_W  10   line-RAM address width; must satisfy 2**ADDR_W >= WIDTH
//
// PORTS
// - clk      in   1       clock
// - reset    in   1       synchronous, active-high
// - i_valid  in   1       pixel strobe; no backpressure, a pixel is accepted every cycle i_valid=1
// - i_sof    in   1       start of frame; sampled only when i_valid=1
// - i_data   in   8       pixel, unsigned
// - o_valid  out  1       o_data holds a column
// - o_data   out  24      {[23:16] row r-2, [15:8] row r-1, [7:0] row r}, same column
// - o_done   out  1       one-cycle pulse together with the last column of a frame
// - o_col    out  ADDR_W  column index of o_data
//
// BEHAVIOUR
// - Reset: o_valid=0, o_done=0, o_data=0, o_col=0, col=0, row=0. Line RAMs are not cleared.
// - Latency: exactly 1 cycle. A pixel accepted at cycle t produces o_valid/o_data/o_col at t+1.
// - Idle cycles (i_valid=0): counters and RAMs hold; o_valid=0 and o_done=0 at the next cycle;
//   o_data and o_col hold their last values.
// - Accepted pixel at (row, col):
//   - o_data = {lineA[col], lineB[col], i_data}, using the values read before this cycle's writes.
//   - Writes: lineA[col] <= lineB[col]; lineB[col] <= i_data (two-line cascade).
//   - Counters: col increments; at col=WIDTH-1, col wraps to 0 and row increments.
//   - At row=HEIGHT-1 and col=WIDTH-1, row also wraps to 0.
// - o_valid = 1 only for accepted pixels with row >= 2, so rows 0-1 only prime the RAMs.
// - o_done = 1 with the output for (HEIGHT-1, WIDTH-1). o_done is never asserted while o_valid=0.
// - i_sof: the pixel accepted with i_valid=1 and i_sof=1 is treated as (0,0) whatever the current
//   counter values are; counters restart from there. An early i_sof truncates the frame silently,
//   with no o_done.
// - Simultaneous i_sof with the natural wrap to (0,0): same result; no double effect.
// - Reset mid-frame: counters clear, and the next accepted pixel is (0,0). Stale RAM contents are
//   never emitted, because o_valid is held low until row 2 overwrites both lines.
// - Arithmetic: pass-through only. Counters saturate never; they wrap as stated above.
//
// CONFIGURATION
// - CONV_LB_ZERO_PAD_EN defined:
//   - o_valid=1 for every accepted pixel, including rows 0 and 1.
//   - Missing rows are forced to zero: row 0 gives o_data[23:8]=0; row 1 gives o_data[23:16]=0.
//   - o_done behaviour is unchanged.
// - CONV_LB_ZERO_PAD_EN undefined: rows 0-1 are suppressed as described under BEHAVIOUR.
//
// TESTING (bench parameters WIDTH=4, HEIGHT=4, ADDR_W=2; pixel value = {row[3:0], col[3:0]})
// - Continuous frame, i_valid=1, i_sof with (0,0):
//   - No o_valid during rows 0-1.
//   - Pixel 0x21 -> one cycle later o_valid=1, o_data=0x011121, o_col=1.
//   - Pixel 0x33 -> o_data=0x132333 with o_done=1.
// - i_valid toggling 1/0 across rows 2-3: o_valid pattern mirrors i_valid delayed by 1 cycle;
//   o_data values match the continuous-frame case.
// - Second frame back-to-back: pixel 0x21 of frame 2 -> o_data=0x011121.
//   - Proves the line cascade does not carry frame-1 data into frame 2.
// - i_sof asserted at (2,2) of a frame:
//   - No o_done is issued for the truncated frame.
//   - o_valid stays low for the next 8 accepted pixels.
//   - Pixel 0x20 of the restarted frame -> o_data=0x001020.
// - Reset asserted at (3,1) for 2 cycles: o_valid=0 and o_done=0 during reset and one cycle after.
//   Next frame outputs are correct from row 2.
// - CONV_LB_ZERO_PAD_EN defined:
//   - Pixel 0x00 -> o_valid=1, o_data=0x000000.
//   - Pixel 0x12 -> o_data=0x000212.
//   - Pixel 0x21 -> o_data=0x011121.

Source files
------------

// File: rtl/conv_line_buffer.sv
// Raster pixel stream to 3-row column converter with a two-line RAM cascade and 1-cycle latency.
// Optional build macro CONV_LB_ZERO_PAD_EN emits rows 0-1 with the missing rows forced to zero.
module conv_line_buffer #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic              i_sof,
  input  logic [7:0]        i_data,
  output logic              o_valid,
  output logic [23:0]       o_data,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_col
);

  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(HEIGHT - 1);

  logic [7:0]        line_a_q [WIDTH];
  logic [7:0]        line_b_q [WIDTH];

  logic [ADDR_W-1:0] col_q, col_d, col_cur;
  logic [ROW_W-1:0]  row_q, row_d, row_cur;
  logic [7:0]        rd_a, rd_b;
  logic              row_ge2;
  logic              last_pix;

  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [23:0]       data_q, data_d;
  logic [ADDR_W-1:0] ocol_q, ocol_d;

  // i_sof forces the current pixel to (0,0); a coincident natural wrap lands on the same place.
  always_comb begin
    col_cur  = i_sof ? '0 : col_q;
    row_cur  = i_sof ? '0 : row_q;
    rd_a     = line_a_q[col_cur];
    rd_b     = line_b_q[col_cur];
    row_ge2  = (row_cur > ROW_W'(1));
    last_pix = (row_cur == ROW_LAST) && (col_cur == COL_LAST);

    col_d    = col_q;
    row_d    = row_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    data_d   = data_q;
    ocol_d   = ocol_q;

    if (i_valid) begin
      if (col_cur == COL_LAST) begin
        col_d = '0;
        row_d = (row_cur == ROW_LAST) ? '0 : row_cur + ROW_W'(1);
      end else begin
        col_d = col_cur + ADDR_W'(1);
        row_d = row_cur;
      end

`ifdef CONV_LB_ZERO_PAD_EN
      valid_d = 1'b1;
      if (row_cur == '0) begin
        data_d = {16'h0000, i_data};
      end else if (row_cur == ROW_W'(1)) begin
        data_d = {8'h00, rd_b, i_data};
      end else begin
        data_d = {rd_a, rd_b, i_data};
      end
`else
      valid_d = row_ge2;
      data_d  = {rd_a, rd_b, i_data};
`endif

      done_d = valid_d && last_pix;
      ocol_d = col_cur;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      ocol_q  <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      data_q  <= data_d;
      ocol_q  <= ocol_d;
    end
  end

  // Line RAMs have no reset; reads above see the pre-write contents of this edge.
  always_ff @(posedge clk) begin
    if (!reset && i_valid) begin
      line_a_q[col_cur] <= rd_b;
      line_b_q[col_cur] <= i_data;
    end
  end

  assign o_valid = valid_q;
  assign o_done  = done_q;
  assign o_data  = data_q;
  assign o_col   = ocol_q;

endmodule
